doy_year_counter: RTL

- Sequential date source placed directly upstream of the month/day-of-month decoder.
- Keeps a day-of-year count (doy) and a 4-year leap cycle, and drives the decoder's doy and yearCount inputs.
- Days advance from an internal prescaler or a manual step; the user can load a date.
- Covers the Jan–Apr display window: last day 120, or 121 in a leap year.

---
 rtl/doy_year_counter_pkg.sv | 10 +
 rtl/doy_year_counter_step_sync.sv | 14 +
 rtl/doy_year_counter.sv | 70 +++++++
 3 files changed

// File: rtl/doy_year_counter_pkg.sv
// doy_year_counter_pkg: shared widths, constants and last-day helper for the day-of-year counter
package doy_year_counter_pkg;
    localparam int DOY_W = 8;
    localparam int YEAR_W = 2;
    localparam logic [DOY_W-1:0] DOY_FIRST = 8'd1;
    localparam logic [YEAR_W-1:0] LEAP_IDX = 2'd0;
    function automatic logic [DOY_W-1:0] last_doy(input int base, input logic leap);
        return DOY_W'(base + int'(leap));
    endfunction
endpackage

// File: rtl/doy_year_counter_step_sync.sv
// step_sync_edge: 2-flop synchronizer plus rising-edge pulse for a raw pushbutton level
module step_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s1, s2, s3} <= 3'b000;
        else {s1, s2, s3} <= {din, s1, s2};
    end
    assign pulse = s2 & ~s3;
endmodule

// File: rtl/doy_year_counter.sv
// doy_year_counter: day-of-year and 4-year leap-cycle source for the month/day decoder
// Define ADV_BTN_EN to treat step as a raw pushbutton (synchronized, rising-edge detected).
module doy_year_counter
    import doy_year_counter_pkg::*;
#(
    parameter int TICKS_PER_DAY = 50_000_000,
    parameter int LAST_DOY_BASE = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              load,
    input  logic [DOY_W-1:0]  load_doy,
    input  logic [YEAR_W-1:0] load_year,
    output logic [DOY_W-1:0]  doy,
    output logic              yearCount,
    output logic [YEAR_W-1:0] year_idx,
    output logic              wrap,
    output logic              load_err
);
    localparam int PW = $clog2(TICKS_PER_DAY);
    logic [PW-1:0] pre;
    logic day_tick, step_pulse, adv, load_ok;
    logic [DOY_W-1:0] last;
    logic [YEAR_W-1:0] next_year;
`ifdef ADV_BTN_EN
    step_sync_edge u_step (.clk(clk), .rst_n(rst_n), .din(step), .pulse(step_pulse));
`else
    assign step_pulse = step;
`endif
    assign day_tick  = run && (pre == PW'(TICKS_PER_DAY - 1));
    assign adv       = day_tick | step_pulse;
    assign last      = last_doy(LAST_DOY_BASE, yearCount);
    assign next_year = year_idx + 1'b1;
    assign load_ok   = (load_doy >= DOY_FIRST) &&
                       (load_doy <= last_doy(LAST_DOY_BASE, load_year == LEAP_IDX));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre <= '0;
        else if (load || day_tick) pre <= '0;
        else if (run) pre <= pre + 1'b1;
    end
    // load wins over an advance in the same cycle; a rejected load leaves the date untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doy       <= DOY_FIRST;
            year_idx  <= LEAP_IDX;
            yearCount <= 1'b1;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    doy       <= load_doy;
                    year_idx  <= load_year;
                    yearCount <= (load_year == LEAP_IDX);
                end else load_err <= 1'b1;
            end else if (adv) begin
                if (doy == last) begin
                    doy       <= DOY_FIRST;
                    year_idx  <= next_year;
                    yearCount <= (next_year == LEAP_IDX);
                    wrap      <= 1'b1;
                end else doy <= doy + 1'b1;
            end
        end
    end
endmodule
